// File: rtl/serdes_deser_align.sv
// serdes_deser_align
//   1:N serial-to-parallel deserializer with framed word strobe and bitslip
//   word alignment, for the receive path between the sampled serial pin and
//   the link-layer decoder.
//
//   Optional build macro: SERDES_DESER_AUTO_ALIGN_EN
//     defined   : a HUNT/WAIT/LOCKED aligner searches for ALIGN_PATTERN by
//                 issuing internal slips, and ALIGNED reports lock.
//     undefined : no aligner; ALIGNED is tied high and only BITSLIP slips.
//
//   Output handshake: Q_VALID is a one-cycle strobe with no ready/back-pressure;
//   Q is only meaningful in the cycle Q_VALID is high and holds its value
//   between strobes. A consumer must take the word in that cycle.
module serdes_deser_align #(
   parameter int                    DATA_WIDTH    = 8,
   parameter logic [DATA_WIDTH-1:0] ALIGN_PATTERN = 8'hA5,
   parameter int                    LOSS_COUNT    = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  D,
   input  logic                  BITSLIP,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  Q_VALID,
   output logic                  SLIP_BUSY,
   output logic                  ALIGNED
);

   localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam int HW = $clog2(2 * DATA_WIDTH);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_WIDTH - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(2 * DATA_WIDTH - 1);

   // Elaboration-time guard on the legal parameter ranges
   if (DATA_WIDTH < 2 || DATA_WIDTH > 16) begin : g_bad_width
      $error("serdes_deser_align: DATA_WIDTH must be 2..16");
   end
   if (LOSS_COUNT < 1 || LOSS_COUNT > 15) begin : g_bad_loss
      $error("serdes_deser_align: LOSS_COUNT must be 1..15");
   end
   if ($bits(ALIGN_PATTERN) != DATA_WIDTH) begin : g_bad_pattern
      $error("serdes_deser_align: ALIGN_PATTERN width must equal DATA_WIDTH");
   end

   // Only N-1 history bits are stored; the newest bit comes straight from D
   logic [DATA_WIDTH-2:0] sr;
   logic [DATA_WIDTH-1:0] sr_next;
   logic [CW-1:0]         cnt;
   logic [HW-1:0]         holdoff;
   logic                  int_slip;
   logic                  slip_acc;
   logic                  word_end;
   logic [DATA_WIDTH-1:0] q_r;
   logic                  q_valid_r;
   logic                  aligned_w;

   assign sr_next  = {sr, D};
   // A slip is taken only when no holdoff is running; requests during holdoff are dropped
   assign slip_acc = (BITSLIP | int_slip) && (holdoff == '0);
   // A word closes on the last bit position unless that edge is spent on a slip
   assign word_end = (cnt == CNT_LAST) && !slip_acc;

   // Shift register: one new bit every clock, framing has no effect on it
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sr <= '0;
      else     sr <= sr_next[DATA_WIDTH-2:0];
   end

   // Bit position counter: holds for one edge on an accepted slip
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                  cnt <= '0;
      else if (slip_acc)        cnt <= cnt;
      else if (cnt == CNT_LAST) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
   end

   // Slip holdoff: reloaded by an accepted slip, then counts down to zero
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                 holdoff <= '0;
      else if (slip_acc)       holdoff <= HOLD_LOAD;
      else if (holdoff != '0)  holdoff <= holdoff - 1'b1;
   end

   // Parallel word register and its one-cycle strobe
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q_r       <= '0;
         q_valid_r <= 1'b0;
      end else begin
         q_valid_r <= word_end;
         if (word_end) q_r <= sr_next;
      end
   end

   assign Q         = q_r;
   assign Q_VALID   = q_valid_r;
   assign SLIP_BUSY = (holdoff != '0);
   assign ALIGNED   = aligned_w;

`ifdef SERDES_DESER_AUTO_ALIGN_EN
   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_LOCKED = 2'd2
   } align_state_t;

   localparam logic [3:0] LOSS_LAST = 4'(LOSS_COUNT - 1);

   align_state_t align_state;
   align_state_t align_state_nxt;
   logic [3:0]   loss_cnt;
   logic [3:0]   loss_cnt_nxt;
   logic         pat_match;

   assign pat_match = (q_r == ALIGN_PATTERN);

   // Aligner state and loss counter registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         align_state <= ST_HUNT;
         loss_cnt    <= '0;
      end else begin
         align_state <= align_state_nxt;
         loss_cnt    <= loss_cnt_nxt;
      end
   end

   // Aligner next state: each strobed word is judged once
   always_comb begin
      align_state_nxt = align_state;
      loss_cnt_nxt    = loss_cnt;
      case (align_state)
         ST_HUNT: begin
            if (q_valid_r) begin
               loss_cnt_nxt = '0;
               if (pat_match) align_state_nxt = ST_LOCKED;
               else           align_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Words arriving while the slip settles are not judged
            if (holdoff == '0) align_state_nxt = ST_HUNT;
         end
         ST_LOCKED: begin
            if (q_valid_r) begin
               if (pat_match) begin
                  loss_cnt_nxt = '0;
               end else if (loss_cnt == LOSS_LAST) begin
                  loss_cnt_nxt    = '0;
                  align_state_nxt = ST_HUNT;
               end else begin
                  loss_cnt_nxt = loss_cnt + 1'b1;
               end
            end
         end
         default: begin
            align_state_nxt = ST_HUNT;
            loss_cnt_nxt    = '0;
         end
      endcase
   end

   // Aligner outputs: slip request on a mismatch in HUNT, lock flag in LOCKED
   always_comb begin
      int_slip  = 1'b0;
      aligned_w = 1'b0;
      case (align_state)
         ST_HUNT:   int_slip  = q_valid_r && !pat_match;
         ST_LOCKED: aligned_w = 1'b1;
         default:   ;
      endcase
   end
`else
   assign int_slip  = 1'b0;
   assign aligned_w = 1'b1;
`endif

endmodule

// File: tb/tb_serdes_deser_align.sv
// tb_serdes_deser_align
//   Directed bench: an 8-bit instance carries the framing, bitslip, holdoff and
//   reset scenarios; 2-bit and 16-bit instances check framing at the width
//   extremes. The aligner scenario is built when SERDES_DESER_AUTO_ALIGN_EN is set.
module tb_serdes_deser_align;

   logic        clk;
   logic        rst;
   logic        d8, bs8, qv8, busy8, al8;
   logic [7:0]  q8;
   logic        d2, bs2, qv2, busy2, al2;
   logic [1:0]  q2;
   logic        d16, bs16, qv16, busy16, al16;
   logic [15:0] q16;

   int total;
   int bad;

   // 8-bit stream source: words come from tx_q, 0xA5 when it is empty
   logic [7:0]  tx_q[$];
   logic [7:0]  cur_word;
   int          bitpos;
   logic [15:0] exp_q[$];

`ifdef SERDES_DESER_AUTO_ALIGN_EN
   localparam logic EXP_AL_RST = 1'b0;
`else
   localparam logic EXP_AL_RST = 1'b1;
`endif

   serdes_deser_align #(.DATA_WIDTH(8), .ALIGN_PATTERN(8'hA5), .LOSS_COUNT(4)) dut8 (
      .CLK(clk), .RST(rst), .D(d8), .BITSLIP(bs8),
      .Q(q8), .Q_VALID(qv8), .SLIP_BUSY(busy8), .ALIGNED(al8));

   serdes_deser_align #(.DATA_WIDTH(2), .ALIGN_PATTERN(2'b10), .LOSS_COUNT(4)) dut2 (
      .CLK(clk), .RST(rst), .D(d2), .BITSLIP(bs2),
      .Q(q2), .Q_VALID(qv2), .SLIP_BUSY(busy2), .ALIGNED(al2));

   serdes_deser_align #(.DATA_WIDTH(16), .ALIGN_PATTERN(16'hA5A5), .LOSS_COUNT(4)) dut16 (
      .CLK(clk), .RST(rst), .D(d16), .BITSLIP(bs16),
      .Q(q16), .Q_VALID(qv16), .SLIP_BUSY(busy16), .ALIGNED(al16));

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
      logic [7:0] r;
      r = (v << k) | (v >> (8 - k));
      return r;
   endfunction

   // One bit clock on the 8-bit instance; outputs are sampled 1 time unit after the edge
   task automatic edge8(input logic slip);
      if (bitpos == 0) cur_word = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hA5;
      d8  = cur_word[7 - bitpos];
      bs8 = slip;
      @(posedge clk);
      #1;
      bs8    = 1'b0;
      bitpos = (bitpos + 1) % 8;
   endtask

   task automatic do_reset(input int phase);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      bitpos = phase;
      tx_q.delete();
   endtask

   // Steps until the next strobe; n is the number of edges taken
   task automatic wait_strobe(input int limit, output int n, output logic ok);
      n  = 0;
      ok = 1'b0;
      while (n < limit && !ok) begin
         edge8(1'b0);
         n++;
         if (qv8) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      #1;
      total++;
      if (q8 !== 8'h00 || qv8 !== 1'b0 || busy8 !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: q=%h qv=%b busy=%b, need q=00 qv=0 busy=0", q8, qv8, busy8);
      end
      total++;
      if (al8 !== EXP_AL_RST) begin
         bad++;
         $display("FAIL reset_aligned: got %b need %b", al8, EXP_AL_RST);
      end
      total++;
      if (q2 !== 2'b00 || q16 !== 16'h0000 || qv2 !== 1'b0 || qv16 !== 1'b0) begin
         bad++;
         $display("FAIL reset_widths: q2=%h q16=%h qv2=%b qv16=%b, need zeros", q2, q16, qv2, qv16);
      end
   endtask

   task automatic test_first_word;
      logic [7:0] exp_q8;
      do_reset(0);
      for (int i = 1; i <= 24; i++) begin
         edge8(1'b0);
         exp_q8 = (i < 8) ? 8'h00 : 8'hA5;
         total++;
         if (qv8 !== (i % 8 == 0)) begin
            bad++;
            $display("FAIL first_word_strobe edge %0d: got %b need %b", i, qv8, (i % 8 == 0));
         end
         total++;
         if (q8 !== exp_q8) begin
            bad++;
            $display("FAIL first_word_q edge %0d: got %h need %h", i, q8, exp_q8);
         end
      end
   endtask

   task automatic test_bitslip;
      int   n;
      logic ok;
      for (int k = 1; k <= 8; k++) begin
         edge8(1'b1);
         total++;
         if (busy8 !== 1'b1 || qv8 !== 1'b0) begin
            bad++;
            $display("FAIL slip_accept k=%0d: busy=%b qv=%b, need busy=1 qv=0", k, busy8, qv8);
         end
         wait_strobe(16, n, ok);
         total++;
         if (!ok || n != 8 || q8 !== rotl8(8'hA5, k)) begin
            bad++;
            $display("FAIL slip_word k=%0d: ok=%b gap=%0d q=%h, need gap=8 q=%h", k, ok, n, q8, rotl8(8'hA5, k));
         end
         wait_strobe(16, n, ok);
         total++;
         if (!ok || n != 8 || q8 !== rotl8(8'hA5, k)) begin
            bad++;
            $display("FAIL slip_hold_word k=%0d: ok=%b gap=%0d q=%h, need gap=8 q=%h", k, ok, n, q8, rotl8(8'hA5, k));
         end
      end
   endtask

   task automatic test_slip_hold;
      int   accepts;
      logic prev_busy;
      logic exp_busy;
      accepts   = 0;
      prev_busy = busy8;
      for (int i = 1; i <= 32; i++) begin
         edge8(i <= 20);
         exp_busy = !(i == 16 || i >= 32);
         total++;
         if (busy8 !== exp_busy) begin
            bad++;
            $display("FAIL hold_busy edge %0d: got %b need %b", i, busy8, exp_busy);
         end
         if (busy8 && !prev_busy) accepts++;
         prev_busy = busy8;
      end
      total++;
      if (accepts != 2) begin
         bad++;
         $display("FAIL hold_accepts: got %0d need 2", accepts);
      end
   endtask

   task automatic test_reset_midword;
      int   n;
      logic ok;
      wait_strobe(16, n, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL midword_prestrobe: no strobe within 16 edges");
      end
      edge8(1'b1);
      edge8(1'b0);
      edge8(1'b0);
      total++;
      if (busy8 !== 1'b1 || q8 === 8'h00) begin
         bad++;
         $display("FAIL midword_setup: busy=%b q=%h, need busy=1 q nonzero", busy8, q8);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (q8 !== 8'h00 || qv8 !== 1'b0 || busy8 !== 1'b0) begin
         bad++;
         $display("FAIL midword_async: q=%h qv=%b busy=%b, need 00/0/0", q8, qv8, busy8);
      end
      @(posedge clk);
      #1;
      rst    = 1'b0;
      bitpos = 0;
      tx_q.delete();
      for (int i = 1; i <= 8; i++) begin
         edge8(1'b0);
         total++;
         if (qv8 !== (i == 8)) begin
            bad++;
            $display("FAIL midword_restart edge %0d: qv got %b need %b", i, qv8, (i == 8));
         end
      end
      total++;
      if (q8 !== 8'hA5) begin
         bad++;
         $display("FAIL midword_restart_q: got %h need a5", q8);
      end
   endtask

   task automatic test_widths;
      logic [1:0]  w2;
      logic [15:0] w16;
      logic [15:0] exp16;
      do_reset(0);
      exp_q.delete();
      for (int i = 0; i < 48; i++) begin
         w2  = 2'((i / 2) % 4);
         w16 = 16'(i / 16 + 1);
         d2  = w2[1 - (i % 2)];
         d16 = w16[15 - (i % 16)];
         if (i % 16 == 15) exp_q.push_back(w16);
         @(posedge clk);
         #1;
         total++;
         if (qv2 !== ((i + 1) % 2 == 0) || (qv2 && q2 !== w2)) begin
            bad++;
            $display("FAIL width2 bit %0d: qv=%b q=%h, need qv=%b q=%h", i, qv2, q2, ((i + 1) % 2 == 0), w2);
         end
         total++;
         if (qv16 !== ((i + 1) % 16 == 0)) begin
            bad++;
            $display("FAIL width16_strobe bit %0d: got %b need %b", i, qv16, ((i + 1) % 16 == 0));
         end
         if (qv16) begin
            exp16 = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            total++;
            if (q16 !== exp16) begin
               bad++;
               $display("FAIL width16_word bit %0d: got %h need %h", i, q16, exp16);
            end
         end
      end
   endtask

`ifdef SERDES_DESER_AUTO_ALIGN_EN
   task automatic test_auto_align;
      int   n;
      logic ok;
      do_reset(3);
      n = 0;
      while (n < 8 * 24 + 16 && al8 !== 1'b1) begin
         edge8(1'b0);
         n++;
      end
      total++;
      if (al8 !== 1'b1 || q8 !== 8'hA5) begin
         bad++;
         $display("FAIL align_lock: aligned=%b q=%h after %0d edges, need 1 and a5", al8, q8, n);
      end
      wait_strobe(16, n, ok);
      repeat (3) tx_q.push_back(8'h00);
      for (int b = 1; b <= 3; b++) wait_strobe(16, n, ok);
      total++;
      if (q8 !== 8'h00) begin
         bad++;
         $display("FAIL align_bad3_word: got %h need 00", q8);
      end
      edge8(1'b0);
      total++;
      if (al8 !== 1'b1) begin
         bad++;
         $display("FAIL align_bad3_lock: got %b need 1", al8);
      end
      wait_strobe(16, n, ok);
      edge8(1'b0);
      total++;
      if (al8 !== 1'b1 || q8 !== 8'hA5) begin
         bad++;
         $display("FAIL align_recover: aligned=%b q=%h need 1 a5", al8, q8);
      end
      wait_strobe(16, n, ok);
      repeat (4) tx_q.push_back(8'h00);
      for (int b = 1; b <= 4; b++) wait_strobe(16, n, ok);
      total++;
      if (al8 !== 1'b1 || q8 !== 8'h00) begin
         bad++;
         $display("FAIL align_bad4_pre: aligned=%b q=%h need 1 00", al8, q8);
      end
      edge8(1'b0);
      total++;
      if (al8 !== 1'b0) begin
         bad++;
         $display("FAIL align_bad4_drop: got %b need 0", al8);
      end
   endtask
`endif

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      d8       = 1'b0;
      bs8      = 1'b0;
      d2       = 1'b0;
      bs2      = 1'b0;
      d16      = 1'b0;
      bs16     = 1'b0;
      bitpos   = 0;
      cur_word = 8'hA5;
      test_reset;
      test_first_word;
`ifdef SERDES_DESER_AUTO_ALIGN_EN
      test_auto_align;
`else
      test_bitslip;
      test_slip_hold;
      test_reset_midword;
      test_widths;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
